// File: rtl/spi_frame_master.sv
// SPI master frame engine (mode 0, MSB first): clocks FRAME_BYTES bytes from a tx
// byte RAM to the slave, framed by frame_n per frame and ss_n per byte, and writes each received byte to an rx RAM.
module spi_frame_master #(
   parameter int FRAME_BYTES = 114,
   parameter int CLK_DIV     = 4,
   parameter int IDX_W       = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [IDX_W-1:0] rx_count,
   output logic [IDX_W-1:0] tx_addr,
   input  logic [7:0]       tx_data,
   output logic             rx_we,
   output logic [IDX_W-1:0] rx_addr,
   output logic [7:0]       rx_data,
   output logic             frame_n,
   output logic             ss_n,
   output logic             sck,
   output logic             mosi,
   input  logic             miso,
   output logic [2:0]       dbgState
);

   typedef enum logic [2:0] {
      IDLE, FRAME_SETUP, FETCH, SS_SETUP, SHIFT, SS_HOLD, BYTE_GAP, FRAME_END
   } stateType;

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

   stateType         state;
   logic [CNT_W-1:0] phaseCnt;
   logic [2:0]       bitCnt;
   logic [IDX_W-1:0] index;
   logic [7:0]       txShift;
   logic [7:0]       rxShift;
   logic             abortLatch;
   logic             phaseDone;

   assign phaseDone = (phaseCnt == CNT_LAST);
   assign dbgState  = state;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         phaseCnt   <= '0;
         bitCnt     <= '0;
         index      <= '0;
         txShift    <= '0;
         rxShift    <= '0;
         abortLatch <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         rx_count   <= '0;
         tx_addr    <= '0;
         rx_we      <= 1'b0;
         rx_addr    <= '0;
         rx_data    <= '0;
         frame_n    <= 1'b1;
         ss_n       <= 1'b1;
         sck        <= 1'b0;
         mosi       <= 1'b0;
      end else begin
         rx_we <= 1'b0;
         done  <= 1'b0;
         // Abort only ends the frame at the next byte boundary, so just remember it.
         if (state != IDLE && state != FRAME_END)
            abortLatch <= abortLatch | abort;

         case (state)
            IDLE: begin
               mosi     <= 1'b0;
               phaseCnt <= '0;
               if (start) begin
                  state      <= FRAME_SETUP;
                  frame_n    <= 1'b0;
                  busy       <= 1'b1;
                  index      <= '0;
                  abortLatch <= 1'b0;
               end
            end
            FRAME_SETUP: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  tx_addr  <= index;
                  state    <= FETCH;
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            FETCH: begin
               // Cycle 1 presents the address, cycle 2 sees the registered RAM data.
               if (phaseCnt == CNT_W'(1)) begin
                  phaseCnt <= '0;
                  txShift  <= tx_data;
                  mosi     <= tx_data[7];
                  ss_n     <= 1'b0;
                  state    <= SS_SETUP;
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            SS_SETUP: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  bitCnt   <= '0;
                  sck      <= 1'b1;
                  rxShift  <= {rxShift[6:0], miso};
                  state    <= SHIFT;
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            SHIFT: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  if (sck) begin
                     sck <= 1'b0;
                     if (bitCnt != 3'd7) begin
                        txShift <= {txShift[6:0], 1'b0};
                        mosi    <= txShift[6];
                     end
                  end else if (bitCnt == 3'd7) begin
                     state <= SS_HOLD;
                  end else begin
                     bitCnt  <= bitCnt + 3'd1;
                     sck     <= 1'b1;
                     rxShift <= {rxShift[6:0], miso};
                  end
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            SS_HOLD: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  ss_n     <= 1'b1;
                  rx_we    <= 1'b1;
                  rx_addr  <= index;
                  rx_data  <= rxShift;
                  state    <= BYTE_GAP;
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            BYTE_GAP: begin
               if (phaseDone) begin
                  phaseCnt <= '0;
                  if (index == IDX_LAST || abortLatch || abort) begin
                     state    <= FRAME_END;
                     frame_n  <= 1'b1;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     mosi     <= 1'b0;
                     rx_count <= index + IDX_W'(1);
                     aborted  <= abortLatch | abort;
                  end else begin
                     index   <= index + IDX_W'(1);
                     tx_addr <= index + IDX_W'(1);
                     state   <= FETCH;
                  end
               end else phaseCnt <= phaseCnt + CNT_W'(1);
            end
            FRAME_END: state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: a 4-byte/H=2 instance for framing, data and
// reset cases, and a default-size instance for the mid-frame abort case.
module tb_spi_frame_master;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset_n = 1'b0;

   int nCompared = 0;
   int nMismatched = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A: FRAME_BYTES=4, CLK_DIV=2 ----------------
   logic       startA = 1'b0, abortA = 1'b0, misoTie = 1'b0;
   logic       busyA, doneA, abortedA, rxWeA, frameNA, ssNA, sckA, mosiA, misoA;
   logic [7:0] rxCountA, txAddrA, txDataA, rxAddrA, rxDataA;
   logic [2:0] dbgA;
   logic [7:0] txMem [256];

   assign misoA = misoTie ? 1'b1 : mosiA;
   always @(posedge clock) txDataA <= txMem[txAddrA];

   spi_frame_master #(.FRAME_BYTES(4), .CLK_DIV(2), .IDX_W(8)) dutA (
      .clock(clock), .reset_n(reset_n), .start(startA), .abort(abortA),
      .busy(busyA), .done(doneA), .aborted(abortedA), .rx_count(rxCountA),
      .tx_addr(txAddrA), .tx_data(txDataA), .rx_we(rxWeA), .rx_addr(rxAddrA),
      .rx_data(rxDataA), .frame_n(frameNA), .ss_n(ssNA), .sck(sckA),
      .mosi(mosiA), .miso(misoA), .dbgState(dbgA)
   );

   // ---------------- instance B: default parameters ----------------
   logic       startB = 1'b0, abortB = 1'b0;
   logic       busyB, doneB, abortedB, rxWeB, frameNB, ssNB, sckB, mosiB;
   logic [7:0] rxCountB, txAddrB, txDataB, rxAddrB, rxDataB;
   logic [2:0] dbgB;

   always @(posedge clock) txDataB <= txAddrB ^ 8'h5A;

   spi_frame_master dutB (
      .clock(clock), .reset_n(reset_n), .start(startB), .abort(abortB),
      .busy(busyB), .done(doneB), .aborted(abortedB), .rx_count(rxCountB),
      .tx_addr(txAddrB), .tx_data(txDataB), .rx_we(rxWeB), .rx_addr(rxAddrB),
      .rx_data(rxDataB), .frame_n(frameNB), .ss_n(ssNB), .sck(sckB),
      .mosi(mosiB), .miso(mosiB), .dbgState(dbgB)
   );

   // ---------------- scoreboard and monitor for A ----------------
   logic [15:0] exp_q [$];
   int   rxWeCnt = 0, ssFalls = 0, frameStarts = 0, doneCnt = 0, sckBad = 0;
   int   pulseCnt = 0, winIdx = 0, lowRun = 0, highRun = 0, lastLow = 0, lastHigh = 0;
   logic [7:0] mosiBits = '0, lastRxCount = '0;
   logic lastAborted = 1'b0;
   logic ssPrev = 1'b1, sckPrev = 1'b0, frPrev = 1'b1;

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (rxWeA === 1'b1) begin
            rxWeCnt++;
            checkVal("rxQueueNonEmpty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) checkVal("rxAddrData", {rxAddrA, rxDataA}, exp_q.pop_front());
         end
         if (ssNA === 1'b0 && ssPrev === 1'b1) begin
            ssFalls++;
            pulseCnt = 0;
            mosiBits = '0;
         end
         if (sckA === 1'b1 && sckPrev === 1'b0) begin
            pulseCnt++;
            mosiBits = {mosiBits[6:0], mosiA};
         end
         if (ssNA === 1'b1 && ssPrev === 1'b0) begin
            checkVal("sckPulses", pulseCnt, 8);
            checkVal("mosiByte", mosiBits, txMem[winIdx]);
            winIdx++;
         end
         if (ssNA === 1'b1 && sckA === 1'b1) sckBad++;
         if (doneA === 1'b1) begin
            doneCnt++;
            lastRxCount = rxCountA;
            lastAborted = abortedA;
            checkVal("doneFrameBusy", {frameNA, busyA}, 2'b10);
         end
         if (frameNA === 1'b0) begin
            if (frPrev === 1'b1) begin
               lastHigh = highRun;
               lowRun = 0;
               winIdx = 0;
               frameStarts++;
            end
            lowRun++;
         end else if (frameNA === 1'b1) begin
            if (frPrev === 1'b0) begin
               lastLow = lowRun;
               highRun = 0;
            end
            highRun++;
         end
      end
      ssPrev  = ssNA;
      sckPrev = sckA;
      frPrev  = frameNA;
   end

   // ---------------- monitor for B ----------------
   int   bIdx = 0, ssFallsB = 0;
   logic ssPrevB = 1'b1, bAborted = 1'b0;
   logic [7:0] bRxCount = '0;

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (rxWeB === 1'b1) begin
            checkVal("bRxAddr", rxAddrB, bIdx);
            checkVal("bRxData", rxDataB, 8'(bIdx) ^ 8'h5A);
            bIdx++;
         end
         if (ssNB === 1'b0 && ssPrevB === 1'b1) ssFallsB++;
         if (doneB === 1'b1) begin
            bRxCount = rxCountB;
            bAborted = abortedB;
         end
      end
      ssPrevB = ssNB;
   end

   // ---------------- driver tasks ----------------
   task automatic pushFrame(input int nBytes, input logic tie);
      for (int i = 0; i < nBytes; i++)
         exp_q.push_back({8'(i), tie ? 8'hFF : txMem[i]});
   endtask

   task automatic pulseStart();
      @(negedge clock);
      startA = 1'b1;
      @(negedge clock);
      startA = 1'b0;
   endtask

   task automatic pulseAbort();
      @(negedge clock);
      abortA = 1'b1;
      @(negedge clock);
      abortA = 1'b0;
   endtask

   task automatic waitDoneA(input int budget);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clock);
         n++;
         if (doneA === 1'b1) seen = 1'b1;
      end
      checkVal("doneSeenA", seen, 1);
   endtask

   task automatic waitRxWe(input int target, input int budget);
      int n = 0;
      while (rxWeCnt < target && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkVal("rxWeSeen", 32'(rxWeCnt >= target), 1);
   endtask

   task automatic checkFrame(input string tag, input int cnt, input logic ab);
      @(negedge clock);
      checkVal({tag, "DonePulse"}, doneA, 0);
      checkVal({tag, "RxCount"}, lastRxCount, cnt);
      checkVal({tag, "Aborted"}, lastAborted, ab);
      checkVal({tag, "QueueEmpty"}, exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int n;
      for (int i = 0; i < 256; i++) txMem[i] = 8'h00;
      txMem[0] = 8'hA5; txMem[1] = 8'h3C; txMem[2] = 8'hFF; txMem[3] = 8'h00;

      repeat (3) @(posedge clock);
      @(negedge clock);
      checkVal("rstCtl", {frameNA, ssNA, sckA, mosiA, busyA, doneA, abortedA, rxWeA}, 8'b1100_0000);
      checkVal("rstRxCount", rxCountA, 0);
      checkVal("rstTxAddr", txAddrA, 0);
      checkVal("rstRxAddr", rxAddrA, 0);
      checkVal("rstCtlB", {frameNB, ssNB, sckB, mosiB, busyB, doneB}, 6'b110000);
      reset_n = 1'b1;

      // loopback frame: bytes come back unchanged, frame length H + 4*(19H+2)
      pushFrame(4, 1'b0);
      pulseStart();
      waitDoneA(400);
      checkFrame("loop", 4, 1'b0);
      checkVal("loopFrameLen", lastLow, 162);

      // miso tied high
      misoTie = 1'b1;
      pushFrame(4, 1'b1);
      pulseStart();
      waitDoneA(400);
      checkFrame("tie", 4, 1'b0);
      misoTie = 1'b0;

      // start held high across two frames
      base = frameStarts;
      pushFrame(4, 1'b0);
      pushFrame(4, 1'b0);
      @(negedge clock);
      startA = 1'b1;
      waitDoneA(400);
      waitDoneA(400);
      startA = 1'b0;
      repeat (10) @(negedge clock);
      checkVal("b2bFrames", frameStarts - base, 2);
      checkVal("b2bIdleGap", lastHigh, 2);
      checkVal("b2bRxCount", lastRxCount, 4);
      checkVal("b2bQueueEmpty", exp_q.size(), 0);

      // abort during byte 1: byte 1 completes, no further ss_n window
      base = ssFalls;
      pushFrame(2, 1'b0);
      pulseStart();
      waitRxWe(rxWeCnt + 1, 200);
      repeat (10) @(negedge clock);
      pulseAbort();
      waitDoneA(400);
      checkFrame("abort1", 2, 1'b1);
      checkVal("abort1SsFalls", ssFalls - base, 2);

      // abort during the final byte
      pushFrame(4, 1'b0);
      base = rxWeCnt;
      pulseStart();
      waitRxWe(base + 3, 400);
      repeat (10) @(negedge clock);
      pulseAbort();
      waitDoneA(400);
      checkFrame("abortLast", 4, 1'b1);

      // abort in IDLE ignored, then start and abort together
      pulseAbort();
      pushFrame(4, 1'b0);
      @(negedge clock);
      startA = 1'b1;
      abortA = 1'b1;
      @(negedge clock);
      startA = 1'b0;
      abortA = 1'b0;
      waitDoneA(400);
      checkFrame("startAbort", 4, 1'b0);

      // reset during SHIFT of byte 1
      exp_q.push_back({8'h00, txMem[0]});
      base = rxWeCnt;
      pulseStart();
      waitRxWe(base + 1, 200);
      repeat (12) @(negedge clock);
      checkVal("rstMidInShift", dbgA, 3'd4);
      reset_n = 1'b0;
      @(negedge clock);
      checkVal("rstMidCtl", {frameNA, ssNA, sckA, busyA, rxWeA}, 5'b11000);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (80) @(negedge clock);
      checkVal("rstMidNoRxWe", rxWeCnt, base + 1);
      checkVal("rstMidQueueEmpty", exp_q.size(), 0);
      pushFrame(4, 1'b0);
      pulseStart();
      waitDoneA(400);
      checkFrame("afterRst", 4, 1'b0);
      checkVal("afterRstFrameLen", lastLow, 162);
      checkVal("sckIdleLow", sckBad, 0);

      // default instance: abort during byte 5
      @(negedge clock);
      startB = 1'b1;
      @(negedge clock);
      startB = 1'b0;
      n = 0;
      while (bIdx < 5 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      checkVal("bReachedByte5", 32'(bIdx >= 5), 1);
      repeat (20) @(negedge clock);
      abortB = 1'b1;
      @(negedge clock);
      abortB = 1'b0;
      n = 0;
      while (doneB !== 1'b1 && n < 12000) begin
         @(negedge clock);
         n++;
      end
      checkVal("bDoneSeen", doneB, 1);
      repeat (20) @(negedge clock);
      checkVal("bRxCount", bRxCount, 6);
      checkVal("bAborted", bAborted, 1);
      checkVal("bBytesWritten", bIdx, 6);
      checkVal("bSsFalls", ssFallsB, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
